// File: rtl/mfp_ahb_gpio_arbiter_pkg.sv
// Shared AHB-Lite encodings and the captured-request record used by the
// two-master GPIO arbiter.
package mfp_ahb_gpio_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } ahb_req_t;

endpackage

// File: rtl/mfp_ahb_arb_port.sv
// One master-side port: captures a transfer, stalls the master until the
// arbiter issues it, then passes the slave data phase back transparently.
module mfp_ahb_arb_port
    import mfp_ahb_gpio_arbiter_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    input  logic        grant,
    input  logic        s_hready,
    input  logic        s_hresp,
    input  logic [31:0] s_hrdata,
    output logic        pend_o,
    output ahb_req_t    req_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0] state_q, state_d;
    ahb_req_t   req_q, req_d;

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        case (state_q)
            ST_WAIT: hready = 1'b0;
            ST_DATA: begin
                hready = s_hready;
                hresp  = s_hresp;
                hrdata = s_hrdata;
            end
            default: ;
        endcase
    end

    // Capture only when the master sees HREADY high, so a transfer offered
    // during the first ERROR cycle and then cancelled is never taken.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: if (htrans[1]) state_d = ST_WAIT;
            ST_WAIT: if (grant && s_hready) state_d = ST_DATA;
            ST_DATA: if (s_hready) state_d = htrans[1] ? ST_WAIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (htrans[1] && hready)
            req_d = '{addr: haddr, write: hwrite, size: hsize};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign pend_o = (state_q == ST_WAIT);
    assign req_o  = req_q;

endmodule

// File: rtl/mfp_ahb_gpio_arbiter.sv
// Shares the GPIO slave between the CPU (port 0) and a debug/DMA master
// (port 1); every transfer is re-issued to the slave as a NONSEQ SINGLE.
module mfp_ahb_gpio_arbiter
    import mfp_ahb_gpio_arbiter_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HWDATA,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    output logic        M0_HRESP,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic        M1_HRESP,
    output logic        S_HSEL,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic [2:0]  S_HSIZE,
    output logic [2:0]  S_HBURST,
    output logic [31:0] S_HWDATA,
    input  logic [31:0] S_HRDATA,
    input  logic        S_HREADY,
    input  logic        S_HRESP
);

    logic [31:0] m_haddr [2];
    logic [1:0]  m_htrans [2];
    logic        m_hwrite [2];
    logic [2:0]  m_hsize [2];
    logic [31:0] m_hwdata [2];
    logic [31:0] m_hrdata [2];
    logic        m_hready [2];
    logic        m_hresp [2];
    logic [1:0]  pend;
    logic [1:0]  grant;
    ahb_req_t    req [2];

    assign m_haddr[0]  = M0_HADDR;
    assign m_haddr[1]  = M1_HADDR;
    assign m_htrans[0] = M0_HTRANS;
    assign m_htrans[1] = M1_HTRANS;
    assign m_hwrite[0] = M0_HWRITE;
    assign m_hwrite[1] = M1_HWRITE;
    assign m_hsize[0]  = M0_HSIZE;
    assign m_hsize[1]  = M1_HSIZE;
    assign m_hwdata[0] = M0_HWDATA;
    assign m_hwdata[1] = M1_HWDATA;
    assign M0_HRDATA   = m_hrdata[0];
    assign M1_HRDATA   = m_hrdata[1];
    assign M0_HREADY   = m_hready[0];
    assign M1_HREADY   = m_hready[1];
    assign M0_HRESP    = m_hresp[0];
    assign M1_HRESP    = m_hresp[1];

    logic grant_vld_q, grant_vld_d;
    logic grant_id_q, grant_id_d;
    logic last_grant_q, last_grant_d;
    logic dph_vld_q, dph_vld_d;
    logic dph_id_q, dph_id_d;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign grant[gi] = grant_vld_q && (grant_id_q == 1'(gi));

        mfp_ahb_arb_port u_port (
            .HCLK     (HCLK),
            .HRESETn  (HRESETn),
            .haddr    (m_haddr[gi]),
            .htrans   (m_htrans[gi]),
            .hwrite   (m_hwrite[gi]),
            .hsize    (m_hsize[gi]),
            .hrdata   (m_hrdata[gi]),
            .hready   (m_hready[gi]),
            .hresp    (m_hresp[gi]),
            .grant    (grant[gi]),
            .s_hready (S_HREADY),
            .s_hresp  (S_HRESP),
            .s_hrdata (S_HRDATA),
            .pend_o   (pend[gi]),
            .req_o    (req[gi])
        );
    end

    // The port whose issue is accepted at this edge leaves WAIT, so it is
    // excluded from the next grant; everything holds while S_HREADY is low.
    logic       accept;
    logic [1:0] cand;

    always_comb begin
        accept       = grant_vld_q && S_HREADY;
        cand[0]      = pend[0] && !(accept && (grant_id_q == 1'b0));
        cand[1]      = pend[1] && !(accept && (grant_id_q == 1'b1));
        grant_vld_d  = grant_vld_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        dph_vld_d    = dph_vld_q;
        dph_id_d     = dph_id_q;
        if (S_HREADY) begin
            grant_vld_d = |cand;
            if (cand[0] && cand[1])
                grant_id_d = (ARB_MODE == 1) ? 1'b0 : ~last_grant_q;
            else
                grant_id_d = cand[1];
            dph_vld_d = 1'b0;
        end
        if (accept) begin
            last_grant_d = grant_id_q;
            dph_vld_d    = 1'b1;
            dph_id_d     = grant_id_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_vld_q  <= 1'b0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            dph_vld_q    <= 1'b0;
            dph_id_q     <= 1'b0;
        end else begin
            grant_vld_q  <= grant_vld_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            dph_vld_q    <= dph_vld_d;
            dph_id_q     <= dph_id_d;
        end
    end

    assign S_HSEL   = grant_vld_q;
    assign S_HTRANS = grant_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign S_HBURST = HBURST_SINGLE;
    assign S_HADDR  = grant_vld_q ? req[grant_id_q].addr : '0;
    assign S_HWRITE = grant_vld_q ? req[grant_id_q].write : 1'b0;
    assign S_HSIZE  = grant_vld_q ? req[grant_id_q].size : '0;
    assign S_HWDATA = dph_vld_q ? m_hwdata[dph_id_q] : '0;

endmodule

// File: tb/tb_mfp_ahb_gpio_arbiter.sv
// Directed bench: two arbiters (round-robin and fixed priority) driven by the
// same master and slave stimulus, checked against hand-computed values.
module tb_mfp_ahb_gpio_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] M0_HADDR = '0, M1_HADDR = '0;
    logic [1:0]  M0_HTRANS = '0, M1_HTRANS = '0;
    logic        M0_HWRITE = 1'b0, M1_HWRITE = 1'b0;
    logic [2:0]  M0_HSIZE = '0, M1_HSIZE = '0;
    logic [31:0] M0_HWDATA = '0, M1_HWDATA = '0;
    logic [31:0] S_HRDATA = '0;
    logic        S_HREADY = 1'b1;
    logic        S_HRESP = 1'b0;

    logic [31:0] m0_hrdata [2];
    logic [31:0] m1_hrdata [2];
    logic        m0_hready [2];
    logic        m1_hready [2];
    logic        m0_hresp [2];
    logic        m1_hresp [2];
    logic        s_hsel [2];
    logic [31:0] s_haddr [2];
    logic [1:0]  s_htrans [2];
    logic        s_hwrite [2];
    logic [2:0]  s_hsize [2];
    logic [2:0]  s_hburst [2];
    logic [31:0] s_hwdata [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    // Instance 0 is round-robin, instance 1 is fixed priority.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mfp_ahb_gpio_arbiter #(.ARB_MODE(gi)) u_dut (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .M0_HADDR  (M0_HADDR),
            .M0_HTRANS (M0_HTRANS),
            .M0_HWRITE (M0_HWRITE),
            .M0_HSIZE  (M0_HSIZE),
            .M0_HWDATA (M0_HWDATA),
            .M0_HRDATA (m0_hrdata[gi]),
            .M0_HREADY (m0_hready[gi]),
            .M0_HRESP  (m0_hresp[gi]),
            .M1_HADDR  (M1_HADDR),
            .M1_HTRANS (M1_HTRANS),
            .M1_HWRITE (M1_HWRITE),
            .M1_HSIZE  (M1_HSIZE),
            .M1_HWDATA (M1_HWDATA),
            .M1_HRDATA (m1_hrdata[gi]),
            .M1_HREADY (m1_hready[gi]),
            .M1_HRESP  (m1_hresp[gi]),
            .S_HSEL    (s_hsel[gi]),
            .S_HADDR   (s_haddr[gi]),
            .S_HTRANS  (s_htrans[gi]),
            .S_HWRITE  (s_hwrite[gi]),
            .S_HSIZE   (s_hsize[gi]),
            .S_HBURST  (s_hburst[gi]),
            .S_HWDATA  (s_hwdata[gi]),
            .S_HRDATA  (S_HRDATA),
            .S_HREADY  (S_HREADY),
            .S_HRESP   (S_HRESP)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [31:0] got0,
                            input logic [31:0] got1, input logic [31:0] exp);
        chk({tag, "[rr]"}, got0, exp);
        chk({tag, "[fp]"}, got1, exp);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk_both({tag, "_htrans"}, s_htrans[0], s_htrans[1], 32'h0);
        chk_both({tag, "_hsel"}, s_hsel[0], s_hsel[1], 32'h0);
        chk_both({tag, "_haddr"}, s_haddr[0], s_haddr[1], 32'h0);
        chk_both({tag, "_hwdata"}, s_hwdata[0], s_hwdata[1], 32'h0);
        chk_both({tag, "_m0_hready"}, m0_hready[0], m0_hready[1], 32'h1);
        chk_both({tag, "_m1_hready"}, m1_hready[0], m1_hready[1], 32'h1);
        chk_both({tag, "_m1_hresp"}, m1_hresp[0], m1_hresp[1], 32'h0);
        chk_both({tag, "_m0_hrdata"}, m0_hrdata[0], m0_hrdata[1], 32'h0);
        chk_both({tag, "_m1_hrdata"}, m1_hrdata[0], m1_hrdata[1], 32'h0);
    endtask

    // Uncontended M0 word write: two wait states, issue one cycle after capture.
    task automatic m0_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        step();
        M0_HTRANS = 2'b10; M0_HADDR = addr; M0_HWRITE = 1'b1; M0_HSIZE = 3'd2;
        #1 chk_both({tag, "_c0_hready"}, m0_hready[0], m0_hready[1], 32'h1);
        step();
        M0_HTRANS = 2'b00; M0_HWDATA = data;
        #1 chk_both({tag, "_c1_hready"}, m0_hready[0], m0_hready[1], 32'h0);
        chk_both({tag, "_c1_htrans"}, s_htrans[0], s_htrans[1], 32'h0);
        step();
        #1 chk_both({tag, "_c2_htrans"}, s_htrans[0], s_htrans[1], 32'h2);
        chk_both({tag, "_c2_haddr"}, s_haddr[0], s_haddr[1], addr);
        chk_both({tag, "_c2_hwrite"}, s_hwrite[0], s_hwrite[1], 32'h1);
        chk_both({tag, "_c2_hsize"}, s_hsize[0], s_hsize[1], 32'h2);
        chk_both({tag, "_c2_hburst"}, s_hburst[0], s_hburst[1], 32'h0);
        chk_both({tag, "_c2_hsel"}, s_hsel[0], s_hsel[1], 32'h1);
        chk_both({tag, "_c2_hready"}, m0_hready[0], m0_hready[1], 32'h0);
        step();
        #1 chk_both({tag, "_c3_hwdata"}, s_hwdata[0], s_hwdata[1], data);
        chk_both({tag, "_c3_hready"}, m0_hready[0], m0_hready[1], 32'h1);
        chk_both({tag, "_c3_htrans"}, s_htrans[0], s_htrans[1], 32'h0);
        step();
        M0_HWRITE = 1'b0;
        #1 chk_both({tag, "_c4_hready"}, m0_hready[0], m0_hready[1], 32'h1);
        $display("txn %s: M0 write 0x%08h = 0x%08h", tag, addr, data);
    endtask

    initial begin
        // Reset with a stray request and live slave data: both must be ignored.
        M0_HTRANS = 2'b10;
        S_HRDATA  = 32'hDEAD_0000;
        step();
        step();
        #1 check_reset_values("rst");
        M0_HTRANS = 2'b00;
        S_HRDATA  = '0;
        step();
        HRESETn = 1'b1;
        step();
        $display("txn reset: outputs at reset values");

        // Simultaneous reads after reset: M0 first in both modes, M1 pipelined.
        step();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h10;
        M1_HTRANS = 2'b11; M1_HADDR = 32'h20;
        step();
        M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
        #1 chk_both("sim_c1_m0_hready", m0_hready[0], m0_hready[1], 32'h0);
        chk_both("sim_c1_m1_hready", m1_hready[0], m1_hready[1], 32'h0);
        step();
        #1 chk_both("sim_c2_haddr", s_haddr[0], s_haddr[1], 32'h10);
        chk_both("sim_c2_htrans", s_htrans[0], s_htrans[1], 32'h2);
        step();
        S_HRDATA = 32'h1111;
        #1 chk_both("sim_c3_haddr", s_haddr[0], s_haddr[1], 32'h20);
        chk_both("sim_c3_htrans", s_htrans[0], s_htrans[1], 32'h2);
        chk_both("sim_c3_m0_hrdata", m0_hrdata[0], m0_hrdata[1], 32'h1111);
        chk_both("sim_c3_m0_hready", m0_hready[0], m0_hready[1], 32'h1);
        chk_both("sim_c3_m1_hrdata", m1_hrdata[0], m1_hrdata[1], 32'h0);
        chk_both("sim_c3_m1_hready", m1_hready[0], m1_hready[1], 32'h0);
        step();
        S_HRDATA = 32'h2222;
        #1 chk_both("sim_c4_m1_hrdata", m1_hrdata[0], m1_hrdata[1], 32'h2222);
        chk_both("sim_c4_m1_hready", m1_hready[0], m1_hready[1], 32'h1);
        chk_both("sim_c4_m0_hrdata", m0_hrdata[0], m0_hrdata[1], 32'h0);
        chk_both("sim_c4_htrans", s_htrans[0], s_htrans[1], 32'h0);
        step();
        S_HRDATA = '0;
        $display("txn sim: M0 read 0x10, M1 read 0x20");

        m0_write("wr", 32'hBF80_0000, 32'h0000_00A5);

        // last_grant is now 0: round-robin picks M1, fixed priority picks M0.
        step();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h30;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h34;
        step();
        M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
        step();
        #1 chk("mode_c2_haddr[rr]", s_haddr[0], 32'h34);
        chk("mode_c2_haddr[fp]", s_haddr[1], 32'h30);
        step();
        S_HRDATA = 32'h3333;
        #1 chk("mode_c3_haddr[rr]", s_haddr[0], 32'h30);
        chk("mode_c3_haddr[fp]", s_haddr[1], 32'h34);
        chk("mode_c3_m1_hrdata[rr]", m1_hrdata[0], 32'h3333);
        chk("mode_c3_m0_hrdata[rr]", m0_hrdata[0], 32'h0);
        chk("mode_c3_m0_hready[rr]", m0_hready[0], 32'h0);
        chk("mode_c3_m0_hrdata[fp]", m0_hrdata[1], 32'h3333);
        chk("mode_c3_m1_hrdata[fp]", m1_hrdata[1], 32'h0);
        chk("mode_c3_m1_hready[fp]", m1_hready[1], 32'h0);
        step();
        S_HRDATA = 32'h4444;
        #1 chk("mode_c4_m0_hrdata[rr]", m0_hrdata[0], 32'h4444);
        chk("mode_c4_m1_hrdata[fp]", m1_hrdata[1], 32'h4444);
        step();
        S_HRDATA = '0;
        $display("txn mode: contended reads 0x30/0x34");

        // Three slave wait states in M0's data phase with M1's issue pending.
        step();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h50;
        step();
        M0_HTRANS = 2'b00;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h54;
        #1 chk_both("ws_c1_m0_hready", m0_hready[0], m0_hready[1], 32'h0);
        step();
        M1_HTRANS = 2'b00;
        #1 chk_both("ws_c2_haddr", s_haddr[0], s_haddr[1], 32'h50);
        chk_both("ws_c2_m1_hready", m1_hready[0], m1_hready[1], 32'h0);
        for (int w = 0; w < 3; w++) begin
            step();
            S_HREADY = 1'b0;
            #1 chk_both($sformatf("ws_w%0d_haddr", w), s_haddr[0], s_haddr[1], 32'h54);
            chk_both($sformatf("ws_w%0d_htrans", w), s_htrans[0], s_htrans[1], 32'h2);
            chk_both($sformatf("ws_w%0d_m0_hready", w), m0_hready[0], m0_hready[1], 32'h0);
            chk_both($sformatf("ws_w%0d_m1_hready", w), m1_hready[0], m1_hready[1], 32'h0);
        end
        step();
        S_HREADY = 1'b1; S_HRDATA = 32'h5555;
        #1 chk_both("ws_c6_m0_hready", m0_hready[0], m0_hready[1], 32'h1);
        chk_both("ws_c6_m0_hrdata", m0_hrdata[0], m0_hrdata[1], 32'h5555);
        chk_both("ws_c6_haddr", s_haddr[0], s_haddr[1], 32'h54);
        step();
        S_HRDATA = 32'h6666;
        #1 chk_both("ws_c7_m1_hready", m1_hready[0], m1_hready[1], 32'h1);
        chk_both("ws_c7_m1_hrdata", m1_hrdata[0], m1_hrdata[1], 32'h6666);
        chk_both("ws_c7_htrans", s_htrans[0], s_htrans[1], 32'h0);
        step();
        S_HRDATA = '0;
        $display("txn ws: M0 read 0x50 with 3 wait states, M1 read 0x54");

        // Two-cycle ERROR to M1; its request offered in the first cycle is dropped.
        step();
        M1_HTRANS = 2'b10; M1_HADDR = 32'h58;
        step();
        M1_HTRANS = 2'b00;
        step();
        #1 chk_both("err_c2_haddr", s_haddr[0], s_haddr[1], 32'h58);
        step();
        S_HREADY = 1'b0; S_HRESP = 1'b1;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h5C;
        #1 chk_both("err_e1_m1_hresp", m1_hresp[0], m1_hresp[1], 32'h1);
        chk_both("err_e1_m1_hready", m1_hready[0], m1_hready[1], 32'h0);
        chk_both("err_e1_m0_hresp", m0_hresp[0], m0_hresp[1], 32'h0);
        step();
        S_HREADY = 1'b1;
        M1_HTRANS = 2'b00;
        #1 chk_both("err_e2_m1_hresp", m1_hresp[0], m1_hresp[1], 32'h1);
        chk_both("err_e2_m1_hready", m1_hready[0], m1_hready[1], 32'h1);
        chk_both("err_e2_m0_hresp", m0_hresp[0], m0_hresp[1], 32'h0);
        step();
        S_HRESP = 1'b0;
        #1 chk_both("err_c5_m1_hready", m1_hready[0], m1_hready[1], 32'h1);
        chk_both("err_c5_m1_hresp", m1_hresp[0], m1_hresp[1], 32'h0);
        step();
        #1 chk_both("err_c6_htrans", s_htrans[0], s_htrans[1], 32'h0);
        $display("txn err: M1 read 0x58 ERROR, cancelled follow-up");

        // Reset in M1's stalled data phase with M0's issue on the slave bus.
        step();
        M1_HTRANS = 2'b10; M1_HADDR = 32'h60; M1_HWRITE = 1'b1; M1_HSIZE = 3'd2;
        step();
        M1_HTRANS = 2'b00; M1_HWDATA = 32'h99;
        M0_HTRANS = 2'b10; M0_HADDR = 32'h70;
        step();
        M0_HTRANS = 2'b00;
        #1 chk_both("ar_c2_haddr", s_haddr[0], s_haddr[1], 32'h60);
        step();
        S_HREADY = 1'b0; S_HRDATA = 32'hBEEF;
        #1 chk_both("ar_c3_htrans", s_htrans[0], s_htrans[1], 32'h2);
        chk_both("ar_c3_haddr", s_haddr[0], s_haddr[1], 32'h70);
        chk_both("ar_c3_hwdata", s_hwdata[0], s_hwdata[1], 32'h99);
        chk_both("ar_c3_m1_hready", m1_hready[0], m1_hready[1], 32'h0);
        HRESETn = 1'b0;
        #1 check_reset_values("ar");
        step();
        HRESETn = 1'b1; S_HREADY = 1'b1; S_HRDATA = '0;
        M1_HWRITE = 1'b0; M1_HWDATA = '0;
        step();
        $display("txn ar: async reset during M1 data phase");

        m0_write("post_rst_wr", 32'hBF80_0004, 32'h0000_005A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_gpio_arbiter.md
Name: mfp_ahb_gpio_arbiter

Overview:
- Two-master AHB-Lite arbiter that shares the single GPIO slave port between the CPU (master 0) and a secondary master (master 1, debug/DMA).
- Each master transfer is captured into a per-master request register, arbitrated, and re-issued to the slave as a NONSEQ SINGLE.
- Losing or waiting masters are stalled through their own HREADY.
- Sits between the bus matrix GPIO select output and the GPIO slave.

Parameters:
- ARB_MODE, 0, 0 = round-robin between masters; 1 = fixed priority, master 0 wins.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- M0_HADDR / M1_HADDR  in  32  master address
- M0_HTRANS / M1_HTRANS  in  2  master transfer type
- M0_HWRITE / M1_HWRITE  in  1  master write flag
- M0_HSIZE / M1_HSIZE  in  3  master transfer size
- M0_HWDATA / M1_HWDATA  in  32  master write data
- M0_HRDATA / M1_HRDATA  out  32  read data returned to master
- M0_HREADY / M1_HREADY  out  1  ready returned to master
- M0_HRESP / M1_HRESP  out  1  response returned to master
- S_HSEL  out  1  slave select
- S_HADDR  out  32  slave address
- S_HTRANS  out  2  slave transfer type
- S_HWRITE  out  1  slave write flag
- S_HSIZE  out  3  slave transfer size
- S_HBURST  out  3  slave burst type (always SINGLE)
- S_HWDATA  out  32  slave write data
- S_HRDATA  in  32  slave read data
- S_HREADY  in  1  slave ready
- S_HRESP  in  1  slave response

Behaviour:
- Reset: both port FSMs go to IDLE; pending registers are cleared; last_grant = 1, so master 0 wins first under round-robin.
  - Output reset values: S_HTRANS = IDLE, S_HSEL = 0, S_HADDR/S_HWDATA = 0, Mx_HREADY = 1, Mx_HRESP = 0, Mx_HRDATA = 0.
  - Reset is asynchronous and may abort a transfer mid-flight; an in-flight transfer is dropped with no completion.
- Port FSM, one per master: states IDLE, WAIT, DATA.
  - IDLE: Mx_HREADY = 1. On an edge where HTRANS[1] = 1 (NONSEQ or SEQ), capture HADDR, HWRITE, HSIZE into the pending register and go to WAIT. BUSY and IDLE transfers are ignored.
  - WAIT: Mx_HREADY = 0. When this port is granted and S_HREADY = 1 at the edge, go to DATA.
  - DATA: Mx_HREADY = S_HREADY, Mx_HRESP = S_HRESP, Mx_HRDATA = S_HRDATA; S_HWDATA = Mx_HWDATA, since the master holds HWDATA stable while stalled.
    - On an edge where S_HREADY = 1, the transfer completes. If HTRANS[1] = 1 in that same cycle, capture the new request and go to WAIT; otherwise go to IDLE.
  - Outside DATA: Mx_HRESP = 0 and Mx_HRDATA = 0.
- Slave address phase:
  - A granted WAIT port drives S_HADDR/S_HWRITE/S_HSIZE from its pending register, with S_HTRANS = NONSEQ, S_HBURST = SINGLE, S_HSEL = 1.
  - With no grant: S_HTRANS = IDLE and S_HSEL = 0.
  - SEQ requests are re-issued as NONSEQ (bursts are broken into singles).
- Grant rules:
  - Grant is re-evaluated only when the slave address phase is free or is accepted, i.e. at an edge with S_HREADY = 1. While S_HREADY = 0 the grant and address are held stable, as AHB requires.
  - Both ports in WAIT: ARB_MODE 0 grants the port other than last_grant; ARB_MODE 1 grants port 0. last_grant updates when an issue is accepted.
- Pipelining: one port may be in its slave address phase while the other is in DATA. The data-phase owner register selects the S_HWDATA and read-return mux.
- Latency: with a zero-wait slave and no contention, a master sees 2 wait states (capture edge, issue cycle, data cycle).
- Error handling: a two-cycle ERROR response passes through transparently in DATA. Capture happens only when Mx_HREADY = 1, so a master may cancel to IDLE during the first ERROR cycle without effect.
- Constraints: HMASTLOCK and HPROT are not supported. A master never has more than one transfer outstanding.

Decomposition:
- HTRANS_IDLE/BUSY/NONSEQ/SEQ and HBURST_SINGLE encodings come from the shared AHB-Lite include.
- The port FSM state encoding is local to the block.
- Sub-module mfp_ahb_arb_port is instantiated twice. It holds the capture register, the FSM, and the Mx_HREADY/HRESP/HRDATA generation.
- The top level holds grant logic, last_grant, the data-phase owner register, and the slave muxes.

Test Plan:
- M0 write 0xBF800000 = 0x000000A5, M1 idle:
  - S_HTRANS = NONSEQ one cycle after capture; S_HWDATA = 0xA5 in the next cycle; M0_HREADY low for exactly 2 cycles.
- M0 and M1 both issue reads in the same cycle, ARB_MODE 0, after reset:
  - M0 is issued first and M1 is issued in the following cycle (pipelined).
  - M1_HRDATA returns its address's S_HRDATA; M0 never sees M1 data.
- ARB_MODE 1, both masters issuing back-to-back reads continuously:
  - M0 is granted every time both ports are in WAIT.
  - M1 is granted only in cycles where M0 is in IDLE or DATA.
- Slave inserts 3 wait states (S_HREADY = 0) during M0's data phase while M1 is in WAIT:
  - S_HADDR holds M1's address unchanged until S_HREADY = 1.
  - M0_HREADY mirrors S_HREADY.
- Slave returns a two-cycle ERROR to M1:
  - M1_HRESP = 1 for both cycles and M1_HREADY = 0 then 1.
  - M0_HRESP stays 0.
- HRESETn asserted low while M1 is in DATA:
  - All outputs go to their reset values immediately.
  - After release, a new M0 write completes normally.
